// File: rtl/counter_run_controller_if.sv
// Button, rate and count signals between the board controls,
// the run controller and the counter8bit datapath.
interface counter_run_controller_if;
    logic       Start;
    logic       Stop;
    logic       Restart;
    logic [1:0] RateSel;
    logic [7:0] Limit;
    logic [7:0] Count;
    logic       Enable;
    logic       Clear_b;
    logic [1:0] State;
    logic       Done;

    modport master (
        output Start, Stop, Restart, RateSel, Limit, Count,
        input  Enable, Clear_b, State, Done
    );

    modport slave (
        input  Start, Stop, Restart, RateSel, Limit, Count,
        output Enable, Clear_b, State, Done
    );
endinterface

// File: rtl/counter_run_controller.sv
// Run/pause/done sequencer for counter8bit: edge-detected buttons,
// rate-divided Enable pulses and terminal-count halt.
module counter_run_controller #(
    parameter int RATE_W = 26,
    parameter int DIV1   = 49999999,
    parameter int DIV2   = 24999999,
    parameter int DIV3   = 12499999
) (
    input logic Clock,
    input logic Clear,
    counter_run_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic [RATE_W-1:0] div_q, div_d, reload;
    logic start_prev, stop_prev, restart_prev;
    logic ev_start, ev_stop, ev_restart;
    logic clear_b_q, done_q;
    logic tick, at_limit, enable;

    assign ev_start   = bus.Start & ~start_prev;
    assign ev_stop    = bus.Stop & ~stop_prev;
    assign ev_restart = bus.Restart & ~restart_prev;

    always_comb begin
        reload = '0;
        unique case (bus.RateSel)
            2'd0: reload = '0;
            2'd1: reload = RATE_W'(DIV1);
            2'd2: reload = RATE_W'(DIV2);
            2'd3: reload = RATE_W'(DIV3);
            default: reload = '0;
        endcase
    end

    assign tick     = (state_q == RUN) && (div_q == '0);
    assign at_limit = (bus.Count >= bus.Limit);

    // Restart outranks everything, including the pulse of this cycle.
    assign enable = tick & ~at_limit & ~ev_restart;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        if (ev_restart) begin
            state_d = IDLE;
            div_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (ev_start) begin
                        state_d = RUN;
                        div_d   = reload;
                    end
                end
                RUN: begin
                    if (at_limit) begin
                        state_d = DONE;
                    end else if (ev_stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        div_d = reload;
                    end else begin
                        div_d = div_q - RATE_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    div_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q      <= IDLE;
            div_q        <= '0;
            start_prev   <= 1'b0;
            stop_prev    <= 1'b0;
            restart_prev <= 1'b0;
            clear_b_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            start_prev   <= bus.Start;
            stop_prev    <= bus.Stop;
            restart_prev <= bus.Restart;
            clear_b_q    <= ~ev_restart;
            done_q       <= (state_d == DONE);
        end
    end

    assign bus.Enable  = enable;
    assign bus.Clear_b = clear_b_q;
    assign bus.State   = state_q;
    assign bus.Done    = done_q;

endmodule

// File: doc/counter_run_controller.md
Name: counter_run_controller

Overview:
- Sequencer for the 8-bit T-flip-flop counter datapath (counter8bit) that drives that counter's Enable and Clear_b pins.
- Converts start/stop/restart button inputs into a run/pause/done state machine.
- Generates rate-divided one-cycle Enable pulses, selectable from four rates.
- Halts the count at a programmable terminal value. Sits between the board KEY/SW inputs and counter8bit; the count is fed back for terminal detection.

Parameters:
- RATE_W, 26, width of internal rate-divider down-counter
- DIV1, 49999999, reload value for RateSel=1 (1 Hz at 50 MHz)
- DIV2, 24999999, reload value for RateSel=2 (2 Hz)
- DIV3, 12499999, reload value for RateSel=3 (4 Hz); RateSel=0 reload is fixed 0 (every cycle)

Ports:
- Clock  in  1  system clock, all state updates on posedge
- Clear  in  1  asynchronous active-high reset
- Start  in  1  level input; rising edge = start/resume request
- Stop  in  1  level input; rising edge = pause request
- Restart  in  1  level input; rising edge = clear counter and return to IDLE
- RateSel  in  2  Enable pulse rate select
- Limit  in  8  terminal count (unsigned)
- Count  in  8  current counter8bit Q value
- Enable  out  1  to counter8bit Enable; one-cycle pulses
- Clear_b  out  1  to counter8bit Clear_b; active-low, registered
- State  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
- Done  out  1  high when State==DONE

Behaviour:
- Reset (Clear=1, async):
  - State=IDLE; divider=0.
  - Edge-detect registers=0, so an input already high on release counts as an edge on the first clock.
  - Clear_b=0, so the counter is cleared while reset is asserted.
  - Clear_b=1 from the first posedge after Clear falls.
- Edge detect:
  - ev_X = X & ~X_prev; X_prev registered every cycle.
  - Events act on the posedge where the rising level is first sampled.
- Event priority on the same cycle: Restart > Stop > Start.
- Transitions:
  - IDLE: ev_Start -> RUN, divider loaded with reload(RateSel). ev_Stop ignored.
  - RUN: Count >= Limit -> DONE (checked first). ev_Stop -> PAUSE, divider holds.
  - PAUSE: ev_Start -> RUN, divider loaded with reload(RateSel). ev_Stop ignored.
  - DONE: ev_Start and ev_Stop ignored.
  - Any state: ev_Restart -> IDLE; Clear_b driven 0 for exactly one cycle; divider=0.
- Divider:
  - Only decrements in RUN.
  - tick = (divider==0) while in RUN; at tick, the divider reloads reload(RateSel).
  - A RateSel change takes effect at the next reload.
  - First tick after entering RUN occurs reload+1 cycles later. With RateSel=0, tick is every RUN cycle.
- Enable is combinational: (State==RUN) & tick & (Count < Limit). The counter increments on the same posedge.
- Terminal behaviour:
  - Count never exceeds Limit through this block; no 8-bit wrap.
  - Limit=0: Start leads to RUN for one cycle, then DONE, with no Enable pulse.
  - Limit lowered below Count mid-run: DONE on the next edge, no further Enable.
- Restart during RUN: the Enable of that cycle is suppressed and Count reads 0 the cycle after the Clear_b pulse.
- Done = (State==DONE); outputs other than Enable are glitch-free registered values.

Test Plan:
- Reset release:
  - Stimulus: Clear pulse, all inputs 0.
  - Required: Clear_b=0 during Clear and =1 one cycle after; State=00; Enable=0.
- Full run at max rate:
  - Stimulus: RateSel=0, Limit=5, Start pulse.
  - Required: Enable high on 5 consecutive cycles; Count 0..5; State=11 and Done=1 the cycle after Count==5; no 6th pulse.
- Divided rate:
  - Stimulus: DIV1 overridden to 3, RateSel=1, Limit=2.
  - Required: Enable pulses 4 cycles apart, the first at cycle 4 after RUN entry; DONE at Count=2.
- Pause/resume:
  - Stimulus: Stop mid-run at Count=3.
  - Required: State=10, no Enable for 20 cycles, Count holds 3.
  - Then Start: counting resumes; DONE reached at Limit.
- Restart:
  - Stimulus: Restart in DONE and in RUN (the RUN case with Start and Stop asserted on the same cycle).
  - Required: Clear_b low exactly one cycle; Count=0; State=00; Start/Stop ignored.
- Boundaries:
  - Stimulus: Limit=0 then Start; separately Limit=255 with RateSel=0.
  - Required: Limit=0 gives immediate DONE with zero pulses. Limit=255 gives 255 pulses, stops at FF, no wrap to 00.
